// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register selectors, register/PC operations, reset vectors
// and the register-file state layout with read/write helpers.
package cpu_pkg;

  typedef enum logic [3:0] {
    RegA    = 4'd0,
    RegB    = 4'd1,
    RegC    = 4'd2,
    RegD    = 4'd3,
    RegE    = 4'd4,
    RegH    = 4'd5,
    RegL    = 4'd6,
    RegW    = 4'd7,
    RegZ    = 4'd8,
    RegBC   = 4'd9,
    RegDE   = 4'd10,
    RegHL   = 4'd11,
    RegWZ   = 4'd12,
    RegSP   = 4'd13,
    RegPC   = 4'd14,
    RegRsvd = 4'd15
  } reg_sel_e;

  typedef enum logic [2:0] {
    RegOpNone     = 3'd0,
    RegOpWriteAlu = 3'd1,
    RegOpWriteMem = 3'd2,
    RegOpInc      = 3'd3,
    RegOpDec      = 3'd4,
    RegOpCopy16   = 3'd5
  } reg_op_e;

  typedef enum logic [1:0] {
    PcNextSame = 2'd0,
    PcNextInc  = 2'd1,
    PcNextReg1 = 2'd2,
    PcNextRst  = 2'd3
  } pc_next_e;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [15:0] RESET_SP_DEFAULT = 16'hFFFE;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [7:0]  d;
    logic [7:0]  e;
    logic [7:0]  h;
    logic [7:0]  l;
    logic [7:0]  w;
    logic [7:0]  z;
    logic [15:0] sp;
    logic [15:0] pc;
  } regs_t;

  function automatic logic is_byte_sel(reg_sel_e sel);
    return (sel <= RegZ);
  endfunction

  function automatic logic [15:0] reg_read(regs_t r, reg_sel_e sel);
    case (sel)
      RegA:    return {8'h00, r.a};
      RegB:    return {8'h00, r.b};
      RegC:    return {8'h00, r.c};
      RegD:    return {8'h00, r.d};
      RegE:    return {8'h00, r.e};
      RegH:    return {8'h00, r.h};
      RegL:    return {8'h00, r.l};
      RegW:    return {8'h00, r.w};
      RegZ:    return {8'h00, r.z};
      RegBC:   return {r.b, r.c};
      RegDE:   return {r.d, r.e};
      RegHL:   return {r.h, r.l};
      RegWZ:   return {r.w, r.z};
      RegSP:   return r.sp;
      RegPC:   return r.pc;
      default: return 16'h0000;
    endcase
  endfunction

  // Byte targets take the low byte; pair targets take both halves in one step.
  function automatic regs_t reg_write(regs_t r, reg_sel_e sel, logic [15:0] v);
    regs_t n;
    n = r;
    case (sel)
      RegA:    n.a = v[7:0];
      RegB:    n.b = v[7:0];
      RegC:    n.c = v[7:0];
      RegD:    n.d = v[7:0];
      RegE:    n.e = v[7:0];
      RegH:    n.h = v[7:0];
      RegL:    n.l = v[7:0];
      RegW:    n.w = v[7:0];
      RegZ:    n.z = v[7:0];
      RegBC:   {n.b, n.c} = v;
      RegDE:   {n.d, n.e} = v;
      RegHL:   {n.h, n.l} = v;
      RegWZ:   {n.w, n.z} = v;
      RegSP:   n.sp = v;
      RegPC:   n.pc = v;
      default: n = r;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cpu_registers_if.sv
// Control/data bundle between the control unit (master) and the register file (slave).
interface cpu_registers_if;
  import cpu_pkg::*;

  logic [1:0]  t_cycle;
  pc_next_e    pc_next;
  logic        inst_load;
  reg_sel_e    reg_read1_sel;
  reg_sel_e    reg_read2_sel;
  reg_sel_e    reg_write_sel;
  reg_op_e     reg_op;
  logic [7:0]  mem_data_in;
  logic [7:0]  alu_out;
  logic [15:0] reg_read1_out;
  logic [15:0] reg_read2_out;
  logic [7:0]  reg_a;
  logic [15:0] pc;
  logic [7:0]  inst;

  modport master (
    output t_cycle, pc_next, inst_load, reg_read1_sel, reg_read2_sel,
           reg_write_sel, reg_op, mem_data_in, alu_out,
    input  reg_read1_out, reg_read2_out, reg_a, pc, inst
  );

  modport slave (
    input  t_cycle, pc_next, inst_load, reg_read1_sel, reg_read2_sel,
           reg_write_sel, reg_op, mem_data_in, alu_out,
    output reg_read1_out, reg_read2_out, reg_a, pc, inst
  );
endinterface

// File: rtl/cpu_reg_read_mux.sv
// Combinational read port: maps a register selector onto zero-extended 16-bit data.
module cpu_reg_read_mux
  import cpu_pkg::*;
(
  input  regs_t       regs_i,
  input  reg_sel_e    sel_i,
  output logic [15:0] data_o
);

  assign data_o = reg_read(regs_i, sel_i);

endmodule

// File: rtl/cpu_registers.sv
// Datapath register file; all state commits once per M-cycle on the edge ending T3.
module cpu_registers
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [15:0] RESET_SP = RESET_SP_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  cpu_registers_if.slave bus
);

  regs_t       regs_q, regs_d;
  logic [7:0]  ir_q, ir_d;
  logic [15:0] rd1, rd2, tgt_val, op_val;
  logic        commit, op_en;

  cpu_reg_read_mux u_rd1 (.regs_i(regs_q), .sel_i(bus.reg_read1_sel), .data_o(rd1));
  cpu_reg_read_mux u_rd2 (.regs_i(regs_q), .sel_i(bus.reg_read2_sel), .data_o(rd2));

  assign commit  = (bus.t_cycle == 2'd3);
  assign tgt_val = reg_read(regs_q, bus.reg_write_sel);

  always_comb begin
    regs_d = regs_q;
    ir_d   = ir_q;
    op_en  = 1'b0;
    op_val = 16'h0000;
    case (bus.reg_op)
      RegOpWriteAlu: begin
        op_en  = is_byte_sel(bus.reg_write_sel);
        op_val = {8'h00, bus.alu_out};
      end
      RegOpWriteMem: begin
        op_en  = is_byte_sel(bus.reg_write_sel);
        op_val = {8'h00, bus.mem_data_in};
      end
      RegOpInc: begin
        op_en  = (bus.reg_write_sel != RegRsvd);
        op_val = tgt_val + 16'd1;
      end
      RegOpDec: begin
        op_en  = (bus.reg_write_sel != RegRsvd);
        op_val = tgt_val - 16'd1;
      end
      RegOpCopy16: begin
        op_en  = (bus.reg_write_sel != RegRsvd);
        op_val = rd1;
      end
      default: op_en = 1'b0;
    endcase
    // Any PC redirect from pc_next takes priority over a reg_op aimed at PC.
    if (bus.reg_write_sel == RegPC && bus.pc_next != PcNextSame) op_en = 1'b0;

    if (commit) begin
      if (op_en) regs_d = reg_write(regs_q, bus.reg_write_sel, op_val);
      case (bus.pc_next)
        PcNextInc:  regs_d.pc = regs_q.pc + 16'd1;
        PcNextReg1: regs_d.pc = rd1;
        PcNextRst:  regs_d.pc = {10'b0, ir_q[5:3], 3'b000};
        default:    regs_d.pc = regs_d.pc;
      endcase
      if (bus.inst_load) ir_d = bus.mem_data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{sp: RESET_SP, pc: RESET_PC, default: '0};
      ir_q   <= 8'h00;
    end else begin
      regs_q <= regs_d;
      ir_q   <= ir_d;
    end
  end

  assign bus.reg_read1_out = rd1;
  assign bus.reg_read2_out = rd2;
  assign bus.reg_a         = regs_q.a;
  assign bus.pc            = regs_q.pc;
  assign bus.inst          = ir_q;

endmodule

// File: tb/tb_cpu_registers.sv
// Directed bench for cpu_registers: one task per feature, inline checks, one summary line.
module tb_cpu_registers;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  cpu_registers_if bus ();

  cpu_registers #(.RESET_PC(16'h0000), .RESET_SP(16'hFFFE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle();
    bus.reg_op        = RegOpNone;
    bus.reg_write_sel = RegA;
    bus.reg_read1_sel = RegRsvd;
    bus.pc_next       = PcNextSame;
    bus.inst_load     = 1'b0;
    bus.mem_data_in   = 8'h00;
    bus.alu_out       = 8'h00;
  endtask

  task automatic set_ctl(input reg_op_e op, input reg_sel_e ws, input reg_sel_e r1,
                         input pc_next_e pn, input logic ld, input logic [7:0] mem,
                         input logic [7:0] alu);
    bus.reg_op        = op;
    bus.reg_write_sel = ws;
    bus.reg_read1_sel = r1;
    bus.pc_next       = pn;
    bus.inst_load     = ld;
    bus.mem_data_in   = mem;
    bus.alu_out       = alu;
  endtask

  // Runs T0..T3; returns just after the commit edge with controls idled.
  task automatic mcycle();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      bus.t_cycle = t[1:0];
    end
    @(negedge clk);
    bus.t_cycle = 2'd0;
    idle();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.t_cycle = 2'd0;
    bus.reg_read2_sel = RegSP;
    idle();
    #12;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++; if (bus.pc !== 16'h0000) begin n_err++; $display("FAIL reset_pc got=%h exp=0000", bus.pc); end
    n_vec++; if (bus.inst !== 8'h00) begin n_err++; $display("FAIL reset_inst got=%h exp=00", bus.inst); end
    n_vec++; if (bus.reg_a !== 8'h00) begin n_err++; $display("FAIL reset_a got=%h exp=00", bus.reg_a); end
    n_vec++; if (bus.reg_read2_out !== 16'hFFFE) begin n_err++; $display("FAIL reset_sp got=%h exp=FFFE", bus.reg_read2_out); end
    // Dirty some state, then reset asynchronously during T1.
    set_ctl(RegOpNone, RegA, RegRsvd, PcNextInc, 1'b1, 8'hAB, 8'h00); mcycle();
    set_ctl(RegOpWriteAlu, RegA, RegRsvd, PcNextSame, 1'b0, 8'h00, 8'h55); mcycle();
    n_vec++; if (bus.pc !== 16'h0001) begin n_err++; $display("FAIL pre_reset_pc got=%h exp=0001", bus.pc); end
    n_vec++; if (bus.reg_a !== 8'h55) begin n_err++; $display("FAIL pre_reset_a got=%h exp=55", bus.reg_a); end
    bus.reg_read1_sel = RegSP;
    @(negedge clk);
    bus.t_cycle = 2'd1;
    #2 reset = 1'b1;
    #1;
    n_vec++; if (bus.pc !== 16'h0000) begin n_err++; $display("FAIL mid_reset_pc got=%h exp=0000", bus.pc); end
    n_vec++; if (bus.inst !== 8'h00) begin n_err++; $display("FAIL mid_reset_inst got=%h exp=00", bus.inst); end
    n_vec++; if (bus.reg_a !== 8'h00) begin n_err++; $display("FAIL mid_reset_a got=%h exp=00", bus.reg_a); end
    n_vec++; if (bus.reg_read1_out !== 16'hFFFE) begin n_err++; $display("FAIL mid_reset_sp got=%h exp=FFFE", bus.reg_read1_out); end
    @(negedge clk);
    reset = 1'b0;
    bus.t_cycle = 2'd0;
    idle();
  endtask

  task automatic test_fetch();
    set_ctl(RegOpWriteMem, RegH, RegRsvd, PcNextSame, 1'b0, 8'h01, 8'h00); mcycle();
    set_ctl(RegOpWriteMem, RegL, RegRsvd, PcNextSame, 1'b0, 8'h00, 8'h00); mcycle();
    set_ctl(RegOpNone, RegA, RegHL, PcNextReg1, 1'b0, 8'h00, 8'h00); mcycle();
    n_vec++; if (bus.pc !== 16'h0100) begin n_err++; $display("FAIL jump_setup_pc got=%h exp=0100", bus.pc); end
    set_ctl(RegOpNone, RegA, RegRsvd, PcNextInc, 1'b1, 8'h3E, 8'h00);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      bus.t_cycle = t[1:0];
      #1;
      n_vec++; if (bus.inst !== 8'h00) begin n_err++; $display("FAIL fetch_hold_inst t=%0d got=%h exp=00", t, bus.inst); end
      n_vec++; if (bus.pc !== 16'h0100) begin n_err++; $display("FAIL fetch_hold_pc t=%0d got=%h exp=0100", t, bus.pc); end
    end
    @(negedge clk);
    bus.t_cycle = 2'd0;
    idle();
    #1;
    n_vec++; if (bus.inst !== 8'h3E) begin n_err++; $display("FAIL fetch_inst got=%h exp=3E", bus.inst); end
    n_vec++; if (bus.pc !== 16'h0101) begin n_err++; $display("FAIL fetch_pc got=%h exp=0101", bus.pc); end
  endtask

  task automatic test_pair_write();
    set_ctl(RegOpWriteMem, RegH, RegRsvd, PcNextSame, 1'b0, 8'hC0, 8'h00); mcycle();
    set_ctl(RegOpWriteMem, RegL, RegHL, PcNextSame, 1'b0, 8'h5A, 8'h00);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      bus.t_cycle = t[1:0];
    end
    #1;
    n_vec++; if (bus.reg_read1_out !== 16'hC000) begin n_err++; $display("FAIL hl_before_commit got=%h exp=C000", bus.reg_read1_out); end
    @(posedge clk);
    #1;
    n_vec++; if (bus.reg_read1_out !== 16'hC05A) begin n_err++; $display("FAIL hl_after_commit got=%h exp=C05A", bus.reg_read1_out); end
    @(negedge clk);
    bus.t_cycle = 2'd0;
    idle();
  endtask

  task automatic test_inc_dec();
    set_ctl(RegOpCopy16, RegSP, RegWZ, PcNextSame, 1'b0, 8'h00, 8'h00); mcycle();
    bus.reg_read2_sel = RegSP; #1;
    n_vec++; if (bus.reg_read2_out !== 16'h0000) begin n_err++; $display("FAIL sp_copy_zero got=%h exp=0000", bus.reg_read2_out); end
    set_ctl(RegOpDec, RegSP, RegRsvd, PcNextSame, 1'b0, 8'h00, 8'h00); mcycle();
    n_vec++; if (bus.reg_read2_out !== 16'hFFFF) begin n_err++; $display("FAIL sp_dec_wrap got=%h exp=FFFF", bus.reg_read2_out); end
    set_ctl(RegOpWriteAlu, RegB, RegRsvd, PcNextSame, 1'b0, 8'h00, 8'hFF); mcycle();
    set_ctl(RegOpWriteAlu, RegC, RegRsvd, PcNextSame, 1'b0, 8'h00, 8'h77); mcycle();
    set_ctl(RegOpInc, RegB, RegRsvd, PcNextSame, 1'b0, 8'h00, 8'h00); mcycle();
    bus.reg_read2_sel = RegBC; #1;
    n_vec++; if (bus.reg_read2_out !== 16'h0077) begin n_err++; $display("FAIL b_inc_wrap_bc got=%h exp=0077", bus.reg_read2_out); end
    set_ctl(RegOpWriteAlu, RegA, RegRsvd, PcNextSame, 1'b0, 8'h00, 8'h99); mcycle();
    n_vec++; if (bus.reg_a !== 8'h99) begin n_err++; $display("FAIL a_write_alu got=%h exp=99", bus.reg_a); end
    bus.reg_read2_sel = RegC; #1;
    n_vec++; if (bus.reg_read2_out !== 16'h0077) begin n_err++; $display("FAIL c_zero_ext got=%h exp=0077", bus.reg_read2_out); end
  endtask

  task automatic test_rst_conflict();
    set_ctl(RegOpNone, RegA, RegRsvd, PcNextInc, 1'b1, 8'hEF, 8'h00); mcycle();
    n_vec++; if (bus.inst !== 8'hEF) begin n_err++; $display("FAIL rst_inst got=%h exp=EF", bus.inst); end
    set_ctl(RegOpInc, RegPC, RegRsvd, PcNextRst, 1'b0, 8'h00, 8'h00); mcycle();
    n_vec++; if (bus.pc !== 16'h0028) begin n_err++; $display("FAIL rst_pc_conflict got=%h exp=0028", bus.pc); end
  endtask

  task automatic test_copy_jump();
    set_ctl(RegOpWriteMem, RegH, RegRsvd, PcNextSame, 1'b0, 8'hD0, 8'h00); mcycle();
    set_ctl(RegOpWriteMem, RegL, RegRsvd, PcNextSame, 1'b0, 8'h00, 8'h00); mcycle();
    set_ctl(RegOpCopy16, RegSP, RegHL, PcNextReg1, 1'b0, 8'h00, 8'h00); mcycle();
    bus.reg_read2_sel = RegSP; #1;
    n_vec++; if (bus.reg_read2_out !== 16'hD000) begin n_err++; $display("FAIL copy_sp got=%h exp=D000", bus.reg_read2_out); end
    n_vec++; if (bus.pc !== 16'hD000) begin n_err++; $display("FAIL jump_pc got=%h exp=D000", bus.pc); end
  endtask

  task automatic test_boundaries();
    set_ctl(RegOpCopy16, RegPC, RegWZ, PcNextSame, 1'b0, 8'h00, 8'h00); mcycle();
    n_vec++; if (bus.pc !== 16'h0000) begin n_err++; $display("FAIL pc_copy16 got=%h exp=0000", bus.pc); end
    set_ctl(RegOpDec, RegPC, RegRsvd, PcNextSame, 1'b0, 8'h00, 8'h00); mcycle();
    n_vec++; if (bus.pc !== 16'hFFFF) begin n_err++; $display("FAIL pc_dec_wrap got=%h exp=FFFF", bus.pc); end
    set_ctl(RegOpNone, RegA, RegRsvd, PcNextInc, 1'b0, 8'h00, 8'h00); mcycle();
    n_vec++; if (bus.pc !== 16'h0000) begin n_err++; $display("FAIL pc_inc_wrap got=%h exp=0000", bus.pc); end
    set_ctl(RegOpWriteMem, RegH, RegRsvd, PcNextSame, 1'b0, 8'hFF, 8'h00); mcycle();
    set_ctl(RegOpWriteMem, RegL, RegRsvd, PcNextSame, 1'b0, 8'hFF, 8'h00); mcycle();
    set_ctl(RegOpInc, RegHL, RegRsvd, PcNextSame, 1'b0, 8'h00, 8'h00); mcycle();
    bus.reg_read2_sel = RegHL; #1;
    n_vec++; if (bus.reg_read2_out !== 16'h0000) begin n_err++; $display("FAIL hl_inc_wrap got=%h exp=0000", bus.reg_read2_out); end
    set_ctl(RegOpWriteAlu, RegDE, RegRsvd, PcNextSame, 1'b0, 8'h00, 8'hAA); mcycle();
    bus.reg_read2_sel = RegDE; #1;
    n_vec++; if (bus.reg_read2_out !== 16'h0000) begin n_err++; $display("FAIL illegal_pair_write got=%h exp=0000", bus.reg_read2_out); end
    set_ctl(RegOpWriteMem, RegSP, RegRsvd, PcNextSame, 1'b0, 8'h12, 8'h00); mcycle();
    bus.reg_read2_sel = RegSP; #1;
    n_vec++; if (bus.reg_read2_out !== 16'hD000) begin n_err++; $display("FAIL illegal_sp_write got=%h exp=D000", bus.reg_read2_out); end
    set_ctl(RegOpCopy16, RegE, RegBC, PcNextSame, 1'b0, 8'h00, 8'h00); mcycle();
    bus.reg_read2_sel = RegDE; #1;
    n_vec++; if (bus.reg_read2_out !== 16'h0077) begin n_err++; $display("FAIL copy16_low_byte got=%h exp=0077", bus.reg_read2_out); end
    bus.reg_read2_sel = RegRsvd; #1;
    n_vec++; if (bus.reg_read2_out !== 16'h0000) begin n_err++; $display("FAIL rsvd_read got=%h exp=0000", bus.reg_read2_out); end
    set_ctl(RegOpWriteAlu, RegA, RegRsvd, PcNextSame, 1'b0, 8'h00, 8'h00); mcycle();
    set_ctl(RegOpDec, RegA, RegRsvd, PcNextSame, 1'b0, 8'h00, 8'h00); mcycle();
    n_vec++; if (bus.reg_a !== 8'hFF) begin n_err++; $display("FAIL a_dec_wrap got=%h exp=FF", bus.reg_a); end
    bus.reg_read2_sel = RegB; #1;
    n_vec++; if (bus.reg_read2_out !== 16'h0000) begin n_err++; $display("FAIL b_untouched got=%h exp=0000", bus.reg_read2_out); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_fetch();
    test_pair_write();
    test_inc_dec();
    test_rst_conflict();
    test_copy_jump();
    test_boundaries();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_registers.md
Name: cpu_registers

Overview:
- Datapath register file directly downstream of the microcoded control unit; consumes its per-state control signals every M-cycle.
- Holds A, B, C, D, E, H, L, temporaries W/Z, SP, PC and the instruction register (IR). Flags live in the ALU, not here.
- Provides two combinational read ports, the A register and the IR (IR feeds condition/RST decode).
- Commits all state updates once per M-cycle, on the clock edge that ends T-cycle 3, in lock-step with control-state advance.

Parameters:
RESET_PC, 16'h0000, PC value after reset (boot ROM entry).
RESET_SP, 16'hFFFE, SP value after reset.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
t_cycle  in  2  current T-cycle within M-cycle (0..3)
pc_next  in  pc_next_e (2)  PC update selection
inst_load  in  1  load IR from mem_data_in
reg_read1_sel  in  reg_sel_e (4)  read port 1 select
reg_read2_sel  in  reg_sel_e (4)  read port 2 select
reg_write_sel  in  reg_sel_e (4)  write/modify target
reg_op  in  reg_op_e (3)  register operation
mem_data_in  in  8  memory read data
alu_out  in  8  ALU result
reg_read1_out  out  16  read port 1 data
reg_read2_out  out  16  read port 2 data
reg_a  out  8  A register
pc  out  16  program counter
inst  out  8  instruction register

Behaviour:
- Reset (async assert, any time, including mid-M-cycle):
  - PC=RESET_PC, SP=RESET_SP.
  - A/B/C/D/E/H/L/W/Z=0, IR=8'h00 (NOP).
  - Therefore reg_a=0 and inst=0.
  - After reset deasserts, the first commit occurs at the next t_cycle==3 edge.
- Read ports: purely combinational from current state.
  - 8-bit selectors (A..Z) zero-extend to 16 bits.
  - Pair selectors BC/DE/HL/WZ are {hi,lo}; SP and PC are 16-bit.
  - Reserved selector 15 reads 16'h0000.
  - A read issued in the same M-cycle as a write returns the old value; the new value is visible after the commit edge.
- Commit: all state updates happen only at posedge clk with t_cycle==3. Nothing changes at t_cycle 0-2.
- reg_op at commit:
  - RegOpNone: no change.
  - RegOpWriteAlu: 8-bit target <= alu_out.
  - RegOpWriteMem: 8-bit target <= mem_data_in.
  - RegOpInc / RegOpDec: target +/- 1, wrapping at the target's own width (8'hFF+1=8'h00; 16'h0000-1=16'hFFFF). Applies to 8-bit and pair targets.
  - RegOpCopy16: pair/SP/PC target <= reg_read1_out.
  - RegOpWriteAlu/WriteMem with a pair, SP, PC or reserved target: no write (illegal; the bench flags it).
  - RegOpCopy16 with an 8-bit target: writes the low byte.
- pc_next at commit:
  - PcNextSame: no change.
  - PcNextInc: PC+1, wrapping 16'hFFFF -> 16'h0000.
  - PcNextReg1: PC <= reg_read1_out.
  - PcNextRst: PC <= {10'b0, inst[5:3], 3'b000}.
- Conflict rule: if pc_next != PcNextSame and reg_op targets PC, pc_next wins and the reg_op is dropped. Otherwise both apply independently.
- inst_load: IR <= mem_data_in at commit. Independent of all other updates; a simultaneous PC increment is legal and is the normal fetch case.
- Writes to a pair update both halves atomically in one commit.

Decomposition:
- Shared package cpu_pkg holds the enums (W* = 16-bit sub-selects):
  - reg_sel_e: A=0, B, C, D, E, H, L, W, Z, BC, DE, HL, WZ, SP, PC, Rsvd=15.
  - reg_op_e: None, WriteAlu, WriteMem, Inc, Dec, Copy16.
  - pc_next_e: Same, Inc, Reg1, Rst.
  - Also RESET vector constants.
- The package is shared with cpu_control and the ALU.
- Optional sub-module cpu_reg_read_mux, instantiated twice, maps reg_sel_e to 16-bit data.

Test Plan:
- Assert reset mid-M-cycle (t_cycle=1) -> pc=0000, reg_read1_out(SP)=FFFE, inst=00 immediately, without waiting for a clock edge.
- Fetch: mem_data_in=8'h3E, inst_load=1, pc_next=Inc, PC=0100 across t_cycle 0..3 -> inst and pc unchanged until the t3 edge, then inst=3E, pc=0101.
- RegOpWriteMem, write_sel=L, mem_data_in=5A, then read1_sel=HL with H=C0 -> reg_read1_out=C05A only after the commit edge.
- RegOpDec on SP=0000 -> FFFF; RegOpInc on B=FF -> B=00 with C unchanged.
- PcNextRst with inst=8'hEF (RST 28h) -> pc=0028; at the same commit, reg_op=Inc with write_sel=PC -> pc=0028 (reg_op dropped).
- RegOpCopy16, write_sel=SP, read1_sel=HL=D000 plus PcNextReg1 -> SP=D000, PC=D000 at the same edge.
